// File: rtl/pc_ras_unit.sv
// Fetch-stage next-PC generator: decodes beq/bne/j/jal/jr, predicts jr $31 from a circular
// return-address stack and holds a late redirect until the icache hits.
module pc_ras_unit #(
  parameter int unsigned PC_WIDTH  = 32,
  parameter int unsigned RAS_DEPTH = 4,
  parameter bit          USE_RAS   = 1'b1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [PC_WIDTH-1:0]          pc_init,
  input  logic                         pc_en,
  input  logic                         ihit,
  input  logic [31:0]                  instr,
  input  logic                         br_taken,
  input  logic [PC_WIDTH-1:0]          reg_loc,
  input  logic                         redirect_valid,
  input  logic [PC_WIDTH-1:0]          redirect_pc,
  input  logic                         ras_flush,
  output logic [PC_WIDTH-1:0]          pcounter,
  output logic [PC_WIDTH-1:0]          n_pc,
  output logic                         ras_pred,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         redirect_pending
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [5:0] OpSpecial = 6'b000000;
  localparam logic [5:0] OpJ       = 6'b000010;
  localparam logic [5:0] OpJal     = 6'b000011;
  localparam logic [5:0] OpBeq     = 6'b000100;
  localparam logic [5:0] OpBne     = 6'b000101;
  localparam logic [5:0] FnJr      = 6'b001000;

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] pend_pc_q, pend_pc_d;
  logic                pend_q, pend_d;
  logic [PtrW-1:0]     top_q, top_d, push_idx;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [PC_WIDTH-1:0] ras_mem_q [RAS_DEPTH];

  logic [PC_WIDTH-1:0] br_off, j_tgt, tgt;
  logic                push, pop;

  assign n_pc     = pc_q + PC_WIDTH'(4);
  assign br_off   = {{(PC_WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
  assign j_tgt    = {n_pc[PC_WIDTH-1:28], instr[25:0], 2'b00};
  assign tgt      = redirect_valid ? redirect_pc : pend_pc_q;
  assign push_idx = top_q + 1'b1;

  always_comb begin
    pc_d      = pc_q;
    pend_d    = pend_q;
    pend_pc_d = pend_pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    ras_pred  = 1'b0;
    if (!RST) begin
      if (redirect_valid || pend_q) begin
        if (ihit) begin
          pc_d   = tgt;
          pend_d = 1'b0;
        end else begin
          pend_pc_d = tgt;
          pend_d    = 1'b1;
        end
      end else if (pc_en && ihit) begin
        case (instr[31:26])
          OpBeq, OpBne: pc_d = br_taken ? n_pc + br_off : n_pc;
          OpJ:          pc_d = j_tgt;
          OpJal: begin
            pc_d = j_tgt;
            push = USE_RAS && !ras_flush;
          end
          OpSpecial: begin
            if (instr[5:0] == FnJr) begin
              // A flush in the same cycle empties the stack, so the jr cannot use it.
              if (USE_RAS && (instr[25:21] == 5'd31) && (cnt_q != '0) && !ras_flush) begin
                pop      = 1'b1;
                ras_pred = 1'b1;
                pc_d     = ras_mem_q[top_q];
              end else begin
                pc_d = reg_loc;
              end
            end else begin
              pc_d = n_pc;
            end
          end
          default: pc_d = n_pc;
        endcase
      end
    end
  end

  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (ras_flush) begin
      top_d = '0;
      cnt_d = '0;
    end else if (push) begin
      top_d = push_idx;
      if (cnt_q != CntW'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
    end else if (pop) begin
      top_d = top_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc_q      <= pc_init;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
      top_q     <= '0;
      cnt_q     <= '0;
    end else begin
      pc_q      <= pc_d;
      pend_q    <= pend_d;
      pend_pc_q <= pend_pc_d;
      top_q     <= top_d;
      cnt_q     <= cnt_d;
    end
  end

  // Entry contents are not reset; a full stack simply overwrites its oldest slot.
  always_ff @(posedge CLK) begin
    if (!RST && push) ras_mem_q[push_idx] <= n_pc;
  end

  assign pcounter         = pc_q;
  assign ras_count        = cnt_q;
  assign redirect_pending = pend_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// Self-checking bench for pc_ras_unit: directed test-plan cases, then random stimulus checked
// against a queue-based behavioural model of the PC and return-address stack.
module tb_pc_ras_unit;

  localparam int unsigned Depth = 4;

  logic        clk;
  logic        rst;
  logic [31:0] pc_init;
  logic        pc_en;
  logic        ihit;
  logic [31:0] instr;
  logic        br_taken;
  logic [31:0] reg_loc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ras_flush;
  logic [31:0] pcounter;
  logic [31:0] n_pc;
  logic        ras_pred;
  logic [2:0]  ras_count;
  logic        redirect_pending;

  pc_ras_unit #(
    .PC_WIDTH (32),
    .RAS_DEPTH(Depth),
    .USE_RAS  (1'b1)
  ) u_dut (
    .CLK             (clk),
    .RST             (rst),
    .pc_init         (pc_init),
    .pc_en           (pc_en),
    .ihit            (ihit),
    .instr           (instr),
    .br_taken        (br_taken),
    .reg_loc         (reg_loc),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .ras_flush       (ras_flush),
    .pcounter        (pcounter),
    .n_pc            (n_pc),
    .ras_pred        (ras_pred),
    .ras_count       (ras_count),
    .redirect_pending(redirect_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [31:0] m_pc;
  bit          m_pend;
  logic [31:0] m_ppc;
  logic [31:0] m_ras[$];
  bit          seen_pred;

  localparam logic [31:0] Jr31 = 32'h03E0_0008;

  // One clock: predict, check combinational outputs before the edge, registers after it.
  task automatic cycle();
    logic [31:0] npc;
    logic [31:0] nxt;
    bit          pred;
    int          off;
    #1;
    npc  = m_pc + 32'd4;
    nxt  = m_pc;
    pred = 0;
    if (rst) begin
      nxt    = pc_init;
      m_pend = 0;
      m_ras.delete();
    end else begin
      if (redirect_valid || m_pend) begin
        if (ihit) begin
          nxt    = redirect_valid ? redirect_pc : m_ppc;
          m_pend = 0;
        end else begin
          m_ppc  = redirect_valid ? redirect_pc : m_ppc;
          m_pend = 1;
        end
      end else if (pc_en && ihit) begin
        case (instr[31:26])
          6'd4, 6'd5: begin
            off = int'($signed(instr[15:0])) * 4;
            nxt = br_taken ? npc + off : npc;
          end
          6'd2: nxt = {npc[31:28], instr[25:0], 2'b00};
          6'd3: begin
            nxt = {npc[31:28], instr[25:0], 2'b00};
            if (!ras_flush) begin
              m_ras.push_back(npc);
              if (m_ras.size() > Depth) void'(m_ras.pop_front());
            end
          end
          6'd0: begin
            if (instr[5:0] == 6'b001000) begin
              if (instr[25:21] == 5'd31 && m_ras.size() > 0 && !ras_flush) begin
                nxt  = m_ras.pop_back();
                pred = 1;
              end else begin
                nxt = reg_loc;
              end
            end else begin
              nxt = npc;
            end
          end
          default: nxt = npc;
        endcase
      end
      if (ras_flush) m_ras.delete();
    end
    if (!rst) check("n_pc", n_pc, npc);
    check("ras_pred", ras_pred, pred);
    seen_pred = ras_pred;
    @(posedge clk);
    #1;
    m_pc = nxt;
    check("pcounter", pcounter, m_pc);
    check("ras_count", ras_count, m_ras.size());
    check("pending", redirect_pending, m_pend);
  endtask

  task automatic idle();
    rst = 0; pc_en = 1; ihit = 1; instr = 32'h0; br_taken = 0;
    reg_loc = 32'hDEAD; redirect_valid = 0; redirect_pc = 0; ras_flush = 0;
  endtask

  task automatic go_to(input logic [31:0] a);
    redirect_valid = 1; redirect_pc = a; ihit = 1;
    cycle();
    redirect_valid = 0; instr = 32'h0;
  endtask

  initial begin
    m_pc = 0; m_pend = 0; m_ppc = 0; seen_pred = 0;
    idle();
    pc_init = 32'h40;

    // Reset then sequential fetch
    rst = 1;
    cycle(); cycle();
    check("rst_pc", pcounter, 32'h40);
    rst = 0;
    cycle();
    check("seq_pc1", pcounter, 32'h44);
    cycle();
    check("seq_pc2", pcounter, 32'h48);
    check("rst_cnt", ras_count, 0);

    // Branches
    go_to(32'h100);
    instr = 32'h1000_FFFE; br_taken = 1;
    cycle();
    check("beq_taken", pcounter, 32'hFC);
    go_to(32'h100);
    instr = 32'h1000_FFFE; br_taken = 0;
    cycle();
    check("beq_not", pcounter, 32'h104);
    br_taken = 0;

    // Call and return
    go_to(32'h200);
    instr = 32'h0C00_0100;
    cycle();
    check("jal_pc", pcounter, 32'h400);
    check("jal_cnt", ras_count, 1);
    instr = Jr31; reg_loc = 32'hDEAD;
    cycle();
    check("ret_pc", pcounter, 32'h204);
    check("ret_pred", seen_pred, 1);
    check("ret_cnt", ras_count, 0);

    // Overflow: five calls into a four-deep stack
    for (int k = 1; k <= 5; k++) begin
      go_to(32'(k * 16));
      instr = 32'h0C00_0100;
      cycle();
    end
    check("ovf_cnt", ras_count, 4);
    for (int k = 0; k < 4; k++) begin
      instr = Jr31;
      cycle();
      check("ovf_ret", pcounter, 32'h54 - 32'(k * 16));
    end
    instr = Jr31; reg_loc = 32'hBEE0;
    cycle();
    check("empty_jr", pcounter, 32'hBEE0);
    check("empty_pred", seen_pred, 0);
    instr = 32'h0;

    // Pending redirect held across a miss
    go_to(32'h500);
    redirect_valid = 1; redirect_pc = 32'h800; ihit = 0;
    cycle(); redirect_valid = 0; cycle(); cycle();
    check("hold_pc", pcounter, 32'h500);
    check("hold_pend", redirect_pending, 1);
    ihit = 1;
    cycle();
    check("apply_pc", pcounter, 32'h800);
    check("apply_pend", redirect_pending, 0);
    redirect_valid = 1; redirect_pc = 32'h800; ihit = 0;
    cycle();
    redirect_pc = 32'h900;
    cycle();
    redirect_valid = 0; ihit = 1;
    cycle();
    check("override", pcounter, 32'h900);

    // Flush beats the pop
    go_to(32'h300);
    instr = 32'h0C00_0100;
    cycle(); cycle();
    check("fl_cnt2", ras_count, 2);
    instr = Jr31; reg_loc = 32'h1234; ras_flush = 1;
    cycle();
    check("fl_pc", pcounter, 32'h1234);
    check("fl_cnt0", ras_count, 0);
    ras_flush = 0; instr = 32'h0;

    // Reset while a redirect is pending
    redirect_valid = 1; redirect_pc = 32'hA00; ihit = 0;
    cycle();
    check("mid_pend", redirect_pending, 1);
    redirect_valid = 0; rst = 1;
    cycle();
    check("mid_rst_pend", redirect_pending, 0);
    check("mid_rst_pc", pcounter, 32'h40);
    rst = 0; ihit = 1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int kind;
      rst            = ($urandom_range(0, 199) == 0);
      pc_init        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      pc_en          = ($urandom_range(0, 99) < 85);
      ihit           = ($urandom_range(0, 99) < 80);
      br_taken       = $urandom_range(0, 1) == 1;
      reg_loc        = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_pc    = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      ras_flush      = ($urandom_range(0, 99) < 4);
      kind           = $urandom_range(0, 7);
      case (kind)
        0:       instr = $urandom;
        1:       instr = {6'b000100, 10'($urandom), 16'($urandom)};
        2:       instr = {6'b000101, 10'($urandom), 16'($urandom)};
        3:       instr = {6'b000010, 26'($urandom)};
        4, 5:    instr = {6'b000011, 26'($urandom)};
        6:       instr = {6'b000000, 5'd31, 15'($urandom), 6'b001000};
        default: instr = {6'b000000, 5'($urandom_range(0, 30)), 15'($urandom), 6'b001000};
      endcase
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised next-generation program counter for the MIPS fetch stage.
- Decodes the fetched word for beq/bne/j/jal/jr and computes the next PC.
- Adds a circular return-address stack (RAS) that predicts jr $31 targets.
- Adds a pending-redirect latch, so a late-stage redirect that arrives while the icache is missing is held and applied on the next ihit.

Parameters:
PC_WIDTH, 32, PC and address width; legal range 32..64.
RAS_DEPTH, 4, RAS entries; power of 2, at least 2.
USE_RAS, 1, 1 = jr $31 predicted from RAS; 0 = RAS never pushed or popped and jr always uses reg_loc.

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  synchronous active-high reset.
pc_init  in  PC_WIDTH  value loaded into pcounter on reset.
pc_en  in  1  advance enable from hazard/stall logic.
ihit  in  1  icache hit for the current fetch.
instr  in  32  instruction fetched at pcounter.
br_taken  in  1  branch condition for beq/bne in instr.
reg_loc  in  PC_WIDTH  rs register value for jr.
redirect_valid  in  1  redirect request from a later stage (mispredict or exception).
redirect_pc  in  PC_WIDTH  redirect target.
ras_flush  in  1  clears the RAS.
pcounter  out  PC_WIDTH  current PC (registered).
n_pc  out  PC_WIDTH  pcounter+4 (combinational, wraps modulo 2^PC_WIDTH).
ras_pred  out  1  combinational; high in a cycle whose update takes a RAS-predicted jr target.
ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries, 0..RAS_DEPTH.
redirect_pending  out  1  a latched redirect is waiting for ihit.

Behaviour:
- All state updates on the CLK rising edge. RST has priority over everything.
- On RST:
  - pcounter=pc_init.
  - ras_count=0; RAS top pointer=0.
  - pend_valid=0 (redirect_pending=0).
  - RAS entry contents are don't-care.
- Redirect stage (highest non-reset priority). Target tgt = redirect_valid ? redirect_pc : pend_pc. A new redirect overrides a pending one.
  - If (redirect_valid or pend_valid) and ihit: pcounter<=tgt; pend_valid<=0.
  - If (redirect_valid or pend_valid) and !ihit: pend_pc<=tgt; pend_valid<=1; pcounter holds.
  - A redirect cycle ignores pc_en and instr: no RAS push or pop occurs.
- Normal update, only when no redirect and no pending redirect exists, pc_en=1 and ihit=1. The opcode is instr[31:26]:
  - beq 000100 / bne 000101: if br_taken, pcounter<=n_pc + (sign-extend(instr[15:0]) to PC_WIDTH, shifted left 2); otherwise pcounter<=n_pc.
  - j 000010: pcounter<={n_pc[PC_WIDTH-1:28], instr[25:0], 2'b00}.
  - jal 000011: same target as j. If USE_RAS, push n_pc.
  - jr (opcode 0, funct instr[5:0]=001000):
    - If USE_RAS, rs (instr[25:21]) =31 and ras_count>0: pop, pcounter<=top entry, ras_pred=1.
    - Otherwise pcounter<=reg_loc, ras_pred=0.
  - Any other instruction: pcounter<=n_pc.
- If pc_en=0 or ihit=0 with no redirect: pcounter holds and the RAS is unchanged.
- RAS push:
  - Write at top+1 (mod RAS_DEPTH) and advance top.
  - ras_count increments, saturating at RAS_DEPTH.
  - Push when full overwrites the oldest entry (circular wrap).
- RAS pop:
  - Read top; top decrements mod RAS_DEPTH; ras_count decrements.
  - Pop when empty never happens: the jr falls back to reg_loc.
- ras_flush: ras_count<=0 and top<=0. It beats a same-cycle push or pop. The PC update still occurs; a jr in that cycle uses reg_loc.
- ras_pred is 0 during reset, redirect and stall cycles.
- The block keeps no delay slot: the return address is pc+4.

Test Plan:
- Reset: pc_init=0x0000_0040, RST high for 2 cycles, then low with pc_en=1, ihit=1, instr=NOP -> pcounter 0x40 then 0x44, 0x48; ras_count=0.
- Branch: pcounter=0x100, instr=beq with imm=0xFFFE, br_taken=1 -> next pcounter=0xFC. Same case with br_taken=0 -> 0x104.
- Call/return: jal 0x000_0100 at pc 0x200 -> pcounter=0x400, ras_count=1. Later, jr $31 with reg_loc=0xDEAD -> pcounter=0x204, ras_pred=1, ras_count=0.
- RAS overflow (RAS_DEPTH=4): 5 jals at pcs 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_count=4. Four jr $31 return 0x54, 0x44, 0x34, 0x24. A fifth jr falls back to reg_loc with ras_pred=0.
- Pending redirect:
  - redirect_valid=1, redirect_pc=0x800 with ihit=0 for 3 cycles -> pcounter holds; redirect_pending=1.
  - Then ihit=1 with redirect_valid=0 -> pcounter=0x800 next edge; redirect_pending=0.
  - A second redirect to 0x900 during the miss wins over 0x800.
- Flush and reset mid-operation: ras_flush with jr $31 at ras_count=2 -> pcounter=reg_loc, ras_count=0. RST asserted while redirect_pending=1 -> pending cleared; pcounter=pc_init.
